modular_multiplication_pipe: RTL

Pipelined Barrett modular multiplier for the NTT butterfly datapath, modulus M = 12289, 14-bit operands. It computes b·w mod M, the twiddle product that feeds the modular add/subtract stage. It has a 4-cycle fixed latency, a global clock-enable for stalls, a valid bit, and a sideband tag channel. The tag carries the butterfly's partner operand or address so it arrives at the add/sub stage aligned with the product.

---
 rtl/modular_multiplication_pipe.sv | 63 ++++++
 1 files changed

// File: rtl/modular_multiplication_pipe.sv
// modular_multiplication_pipe: 4-stage Barrett multiplier computing x*y mod 12289 with valid/tag sideband
module modular_multiplication_pipe #(
  parameter int data_width = 14,
  parameter int tag_width  = 14,
  parameter int M          = 12289,
  parameter int MU         = 21843
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [data_width-1:0] x_mul,
  input  logic [data_width-1:0] y_mul,
  input  logic [tag_width-1:0]  in_tag,
  output logic                  out_valid,
  output logic [data_width-1:0] z_mul,
  output logic [tag_width-1:0]  out_tag
);
  logic [27:0]          r_p1, r_p2;
  logic [42:0]          r_t;
  logic [15:0]          r_r;
  logic [data_width-1:0] r_z;
  logic [3:0]           r_vld;
  logic [tag_width-1:0] r_tag [4];
  logic [14:0]          w_qhat;
  logic [15:0]          w_r, w_z;
  // qhat underestimates the quotient by at most 2, so r fits in 16 bits and the low 16 bits of the difference are exact
  always_comb begin
    w_qhat = 15'(r_t >> 28);
    w_r    = 16'(r_p2) - 16'(28'(w_qhat) * 28'(M));
    w_z    = r_r >= 16'(2 * M) ? r_r - 16'(2 * M) : r_r >= 16'(M) ? r_r - 16'(M) : r_r;
  end
  // datapath stages: product, Barrett estimate, partial remainder, final correction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1 <= '0;
      r_p2 <= '0;
      r_t  <= '0;
      r_r  <= '0;
      r_z  <= '0;
    end else if (en) begin
      r_p1 <= 28'(x_mul) * 28'(y_mul);
      r_t  <= 43'(r_p1) * 43'(MU);
      r_p2 <= r_p1;
      r_r  <= w_r;
      r_z  <= w_z[data_width-1:0];
    end
  end
  // valid and tag shift alongside the data so they stay aligned through stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < 4; i++) r_tag[i] <= '0;
    end else if (en) begin
      r_vld <= {r_vld[2:0], in_valid};
      r_tag[0] <= in_tag;
      for (int i = 1; i < 4; i++) r_tag[i] <= r_tag[i-1];
    end
  end
  assign out_valid = r_vld[3];
  assign z_mul     = r_z;
  assign out_tag   = r_tag[3];
endmodule
